// File: rtl/ibis_texture_pkg.sv
// ibis_texture_pkg
// Shared definitions for the texture-mapper scheduler: the mapper's
// 10-phase ring constants, the scheduler state encoding and a helper
// that advances a phase value around the ring.
package ibis_texture_pkg;

    localparam int         PHASE_COUNT = 10;
    localparam logic [3:0] PHASE_FIRST = 4'd0;
    localparam logic [3:0] PHASE_LAST  = 4'd9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } sched_state_t;

    function automatic logic [3:0] phase_next(input logic [3:0] p);
        return (p == PHASE_LAST) ? PHASE_FIRST : p + 4'd1;
    endfunction

endpackage

// File: rtl/ibis_raster_walker.sv
// ibis_raster_walker
// Walks a rectangle of pixels in raster order (x fastest). The rectangle is
// latched on i_load; every i_step moves to the next pixel and remembers the
// pixel just left in o_prev_x/o_prev_y. On the final pixel a step only
// updates the "previous" coordinates so the last result can still be tagged.
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_load                latch origin/size and restart at the origin
//   i_step                advance one pixel
//   i_x0/i_y0             rectangle origin
//   i_width/i_height      rectangle size (both non-zero when stepped)
//   o_x/o_y               current pixel
//   o_prev_x/o_prev_y     pixel before the most recent step
//   o_last                current pixel is the last in the rectangle
module ibis_raster_walker #(
    parameter int WIDTH = 10
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic             i_step,
    input  logic [WIDTH-1:0] i_x0,
    input  logic [WIDTH-1:0] i_y0,
    input  logic [WIDTH-1:0] i_width,
    input  logic [WIDTH-1:0] i_height,
    output logic [WIDTH-1:0] o_x,
    output logic [WIDTH-1:0] o_y,
    output logic [WIDTH-1:0] o_prev_x,
    output logic [WIDTH-1:0] o_prev_y,
    output logic             o_last
);

    localparam logic [WIDTH-1:0] W_ONE = WIDTH'(1);

    logic [WIDTH-1:0] r_x0;
    logic [WIDTH-1:0] r_w;
    logic [WIDTH-1:0] r_h;
    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_y;
    logic [WIDTH-1:0] r_prev_x;
    logic [WIDTH-1:0] r_prev_y;
    // Column/row counters decide end-of-row and end-of-rectangle, so the
    // test is independent of coordinate wrap-around.
    logic [WIDTH-1:0] r_col;
    logic [WIDTH-1:0] r_row;
    logic             w_row_end;
    logic             w_last;

    assign w_row_end = (r_col == r_w - W_ONE);
    assign w_last    = w_row_end && (r_row == r_h - W_ONE);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_x0     <= '0;
            r_w      <= '0;
            r_h      <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_prev_x <= '0;
            r_prev_y <= '0;
            r_col    <= '0;
            r_row    <= '0;
        end else if (i_load) begin
            r_x0  <= i_x0;
            r_w   <= i_width;
            r_h   <= i_height;
            r_x   <= i_x0;
            r_y   <= i_y0;
            r_col <= '0;
            r_row <= '0;
        end else if (i_step) begin
            r_prev_x <= r_x;
            r_prev_y <= r_y;
            if (!w_last) begin
                if (w_row_end) begin
                    r_col <= '0;
                    r_row <= r_row + W_ONE;
                    r_x   <= r_x0;
                    r_y   <= r_y + W_ONE;
                end else begin
                    r_col <= r_col + W_ONE;
                    r_x   <= r_x + W_ONE;
                end
            end
        end
    end

    assign o_x      = r_x;
    assign o_y      = r_y;
    assign o_prev_x = r_prev_x;
    assign o_prev_y = r_prev_y;
    assign o_last   = w_last;

endmodule

// File: rtl/ibis_texture_scheduler.sv
// ibis_texture_scheduler
// Sequencer for the 10-phase ibis_texture_mapper. Accepts one rectangular
// job at a time, runs one 10-cycle mapper pass per pixel in raster order and
// returns each result through a one-entry output register.
// Ports:
//   aclk, areset                    clock, synchronous active-high reset
//                                   (the mapper's aresetn is ~areset)
//   job_valid/job_ready             job handshake
//   job_x0/y0/width/height          rectangle
//   job_write_matrix, job_matrix_*, job_translate_*   mapper setup values
//   mapper_enable                   mapper advance strobe
//   mapper_write_matrix, mapper_x/y, mapper_matrix_*, mapper_translate_*
//   mapper_map_address, mapper_stencil_test   mapper results
//   pix_valid/pix_ready             result handshake
//   pix_x/y/address/stencil         result payload
//   job_done                        one-cycle completion pulse
//   dbg_state, dbg_phase            FSM state and ring phase
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1; valid never drops and payload never changes until that transfer.
module ibis_texture_scheduler
    import ibis_texture_pkg::*;
#(
    parameter int TILE_SIZE_POW2 = 5,
    parameter int WIDTH          = 10
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic                        job_valid,
    output logic                        job_ready,
    input  logic [WIDTH-1:0]            job_x0,
    input  logic [WIDTH-1:0]            job_y0,
    input  logic [WIDTH-1:0]            job_width,
    input  logic [WIDTH-1:0]            job_height,
    input  logic [5:0]                  job_write_matrix,
    input  logic [11:0]                 job_matrix_a,
    input  logic [11:0]                 job_matrix_b,
    input  logic [11:0]                 job_matrix_c,
    input  logic [11:0]                 job_matrix_d,
    input  logic [11:0]                 job_translate_x,
    input  logic [11:0]                 job_translate_y,
    output logic                        mapper_enable,
    output logic [5:0]                  mapper_write_matrix,
    output logic [WIDTH-1:0]            mapper_x,
    output logic [WIDTH-1:0]            mapper_y,
    output logic [11:0]                 mapper_matrix_a,
    output logic [11:0]                 mapper_matrix_b,
    output logic [11:0]                 mapper_matrix_c,
    output logic [11:0]                 mapper_matrix_d,
    output logic [11:0]                 mapper_translate_x,
    output logic [11:0]                 mapper_translate_y,
    input  logic [2*TILE_SIZE_POW2-1:0] mapper_map_address,
    input  logic                        mapper_stencil_test,
    output logic                        pix_valid,
    input  logic                        pix_ready,
    output logic [WIDTH-1:0]            pix_x,
    output logic [WIDTH-1:0]            pix_y,
    output logic [2*TILE_SIZE_POW2-1:0] pix_address,
    output logic                        pix_stencil,
    output logic                        job_done,
    output sched_state_t                dbg_state,
    output logic [3:0]                  dbg_phase
);

    sched_state_t               r_state;
    logic [3:0]                 r_phase;
    logic                       r_pending;
    logic                       r_first;
    logic                       r_job_ready;
    logic                       r_job_done;
    logic [5:0]                 r_mask;
    logic [11:0]                r_mat_a, r_mat_b, r_mat_c, r_mat_d, r_tr_x, r_tr_y;
    logic                       r_pix_valid;
    logic [WIDTH-1:0]           r_pix_x, r_pix_y;
    logic [2*TILE_SIZE_POW2-1:0] r_pix_addr;
    logic                       r_pix_stencil;

    sched_state_t               w_next_state;
    logic                       w_accept;
    logic                       w_slot_free;
    logic                       w_phase0;
    logic                       w_enable;
    logic                       w_capture;
    logic                       w_done_now;
    logic                       w_step;
    logic                       w_last;
    logic [WIDTH-1:0]           w_prev_x, w_prev_y;

    assign w_accept    = job_valid && r_job_ready;
    // The slot can take a new result if empty or emptied on this edge.
    assign w_slot_free = !r_pix_valid || pix_ready;
    assign w_phase0    = (r_phase == PHASE_FIRST);
    // Phase 9 of an enabled pass ends the pixel; the mapper latches its
    // result on that edge, so the previous pixel's result is stable from
    // the following phase 0 until the next phase 9.
    assign w_step      = (r_state == ISSUE) && w_enable && (r_phase == PHASE_LAST);

    always_comb begin
        w_next_state = r_state;
        w_enable     = 1'b0;
        w_capture    = 1'b0;
        w_done_now   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next_state = (job_width == '0 || job_height == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                w_capture = w_phase0 && r_pending && w_slot_free;
                // Park the ring at phase 0 while an uncaptured result waits.
                w_enable  = !(w_phase0 && r_pending && !w_slot_free);
                if (w_step && w_last) begin
                    w_next_state = DRAIN;
                end
            end
            DRAIN: begin
                w_capture = w_phase0 && r_pending && w_slot_free;
                if (w_capture) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                if (w_slot_free) begin
                    w_done_now   = 1'b1;
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state       <= IDLE;
            r_phase       <= PHASE_FIRST;
            r_pending     <= 1'b0;
            r_first       <= 1'b0;
            r_job_ready   <= 1'b0;
            r_job_done    <= 1'b0;
            r_mask        <= '0;
            r_mat_a       <= '0;
            r_mat_b       <= '0;
            r_mat_c       <= '0;
            r_mat_d       <= '0;
            r_tr_x        <= '0;
            r_tr_y        <= '0;
            r_pix_valid   <= 1'b0;
            r_pix_x       <= '0;
            r_pix_y       <= '0;
            r_pix_addr    <= '0;
            r_pix_stencil <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_job_ready <= (w_next_state == IDLE);
            r_job_done  <= w_done_now;
            if (w_enable) begin
                r_phase <= phase_next(r_phase);
            end
            if (w_accept) begin
                r_mask  <= job_write_matrix;
                r_mat_a <= job_matrix_a;
                r_mat_b <= job_matrix_b;
                r_mat_c <= job_matrix_c;
                r_mat_d <= job_matrix_d;
                r_tr_x  <= job_translate_x;
                r_tr_y  <= job_translate_y;
                r_first <= 1'b1;
            end else if (w_step) begin
                r_first <= 1'b0;
            end
            if (w_step) begin
                r_pending <= 1'b1;
            end else if (w_capture) begin
                r_pending <= 1'b0;
            end
            if (w_capture) begin
                r_pix_valid   <= 1'b1;
                r_pix_x       <= w_prev_x;
                r_pix_y       <= w_prev_y;
                r_pix_addr    <= mapper_map_address;
                r_pix_stencil <= mapper_stencil_test;
            end else if (pix_ready) begin
                r_pix_valid <= 1'b0;
            end
        end
    end

    ibis_raster_walker #(
        .WIDTH (WIDTH)
    ) u_walker (
        .i_clk    (aclk),
        .i_rst    (areset),
        .i_load   (w_accept),
        .i_step   (w_step),
        .i_x0     (job_x0),
        .i_y0     (job_y0),
        .i_width  (job_width),
        .i_height (job_height),
        .o_x      (mapper_x),
        .o_y      (mapper_y),
        .o_prev_x (w_prev_x),
        .o_prev_y (w_prev_y),
        .o_last   (w_last)
    );

    assign job_ready           = r_job_ready;
    assign job_done            = r_job_done;
    assign mapper_enable       = w_enable;
    // Matrix registers are written only once per job, at the very start.
    assign mapper_write_matrix = (r_state == ISSUE && r_first && w_phase0) ? r_mask : 6'd0;
    assign mapper_matrix_a     = r_mat_a;
    assign mapper_matrix_b     = r_mat_b;
    assign mapper_matrix_c     = r_mat_c;
    assign mapper_matrix_d     = r_mat_d;
    assign mapper_translate_x  = r_tr_x;
    assign mapper_translate_y  = r_tr_y;
    assign pix_valid           = r_pix_valid;
    assign pix_x               = r_pix_x;
    assign pix_y               = r_pix_y;
    assign pix_address         = r_pix_addr;
    assign pix_stencil         = r_pix_stencil;
    assign dbg_state           = r_state;
    assign dbg_phase           = r_phase;

endmodule

// File: doc/ibis_texture_scheduler.md
# ibis_texture_scheduler

Sequencer for the 10-phase `ibis_texture_mapper`. It accepts one rectangular texture-mapping job at a time over a valid/ready handshake. It walks the job's pixel rectangle in raster order, driving the mapper's `enable`, matrix-write mask and coordinates, and phase-aligns every input to the mapper's internal one-hot ring. Each mapper result is captured into a one-entry output register with downstream backpressure, and `job_done` pulses once the rectangle has fully drained.

## Interface
Parameters:
- `TILE_SIZE_POW2`, 5, tile edge log2; must match the mapper.
- `WIDTH`, 10, coordinate width; must match the mapper.

Ports:
- `aclk`  in  1  clock; everything is on the rising edge.
- `areset`  in  1  reset. One clock; reset is synchronous and active-high. The top level drives the mapper's `aresetn` as `~areset` from the same edge.
- `job_valid` in 1; `job_ready` out 1: job handshake.
- `job_x0`, `job_y0`, `job_width`, `job_height`  in  WIDTH each  rectangle origin and size.
- `job_write_matrix`  in  6  mapper matrix-register write mask for this job.
- `job_matrix_a/b/c/d`, `job_translate_x/y`  in  12 each  signed matrix and translation values.
- `mapper_enable`  out  1  mapper advance strobe.
- `mapper_write_matrix`  out  6  mask to the mapper.
- `mapper_x`, `mapper_y`  out  WIDTH  current pixel.
- `mapper_matrix_a/b/c/d`, `mapper_translate_x/y`  out  12 each  registered job values.
- `mapper_map_address`  in  2·TILE_SIZE_POW2; `mapper_stencil_test`  in  1: mapper results.
- `pix_valid` out 1; `pix_ready` in 1: result handshake.
- `pix_x`, `pix_y` out WIDTH; `pix_address` out 2·TILE_SIZE_POW2; `pix_stencil` out 1: result payload.
- `job_done`  out  1  single-cycle completion pulse.

## Operation
- `phase` is a mod-10 counter that mirrors the mapper ring. It resets to 0 and increments only on cycles where `mapper_enable`=1.
- State machine:
  - IDLE: `job_ready`=1. On `job_valid`, latch all job fields. Go to ISSUE, or go straight to DONE if width==0 or height==0 (no pixels emitted).
  - ISSUE: one pass of 10 enabled cycles per pixel; `mapper_x/y` are held for the whole pass. On the enabled phase-9 cycle, set `pending`. If this pixel was the last one, go to DRAIN; otherwise advance the coordinates.
  - DRAIN: capture the last result at phase 0 with the mapper parked (`mapper_enable`=0), then go to DONE.
  - DONE: wait until `pix_valid`=0 or the output is being accepted this cycle. Then pulse `job_done` and go to IDLE.
- Raster order: x runs from x0 to x0+width−1, then wraps to x0 and y increments. Coordinate sums wrap modulo 2^WIDTH.
- `mapper_write_matrix` equals the latched mask only on phase 0 of the first pass of a job; it is 0 on every other cycle.
- Capture: when phase==0, `pending`=1 and the output slot is free (or drained this cycle), load `pix_*` from the mapper outputs and the previous pixel's coordinates, set `pix_valid`, and clear `pending`.
- Stall: if phase==0 and `pending`=1 but the slot is not free, `mapper_enable`=0. `map_address` is stable because the mapper only updates it on phase 9.
- Stencil-failing pixels are still emitted, with `pix_stencil`=0.

## Timing
- Reset values: all outputs 0; state IDLE; phase 0; `pending` 0.
- First pixel:
  - Pass occupies cycles 0–9 (cycle 0 is the cycle after the job is accepted).
  - Capture happens on cycle 10, so `pix_valid` is high from cycle 11.
- Throughput is 1 pixel per 10 cycles with no backpressure.
- `job_done` fires on the cycle after the final `pix_valid`&`pix_ready` at the earliest.
- A new job can be accepted the cycle after `job_done`, with the mapper at phase 0.
- `pix_valid` holds its payload stable until accepted.
- Reset asserted mid-job aborts the job and clears every register, including the pending result. No `job_done` is produced.

## Structure
- `ibis_texture_pkg`: phase constants (`PHASE_LAST`=9); the state enum `{IDLE, ISSUE, DRAIN, DONE}`.
- Sub-module `ibis_raster_walker`: latches x0/y0/width/height and advances x/y on a step strobe. Outputs are current x/y, previous x/y, and a `last` flag.

## Test plan
- Reset, then a 1×1 job (x0=3, y0=5, mask=6'h3F, identity matrix A=D=16, translate=0) with `pix_ready`=1: `mapper_write_matrix`=6'h3F on cycle 0 only; `pix_valid` at cycle 11 with x=3, y=5; `job_done` on the next cycle.
- 3×2 job at (126,0) with WIDTH=7: six results in order (126,0), (127,0), (0,0), (126,1), (127,1), (0,1), spaced 10 cycles apart.
- `pix_ready` held low for 25 cycles during a 4×1 job: `mapper_enable`=0 while stalled at phase 0; no result lost or duplicated; the mapper ring stays aligned with `phase`.
- Zero-width job: no `mapper_enable`, no `pix_valid`; `job_done` 1 cycle after accept.
- Two back-to-back jobs where the second has mask=0: `mapper_write_matrix` stays 0 throughout the second job; the second job's first pass starts at phase 0.
- `areset` asserted at phase 5 of a pass: all outputs 0 next cycle, `phase`=0, `job_ready`=1 after release.
